// File: rtl/muldiv_sequencer_pkg.sv
// Shared CPU definitions for the multi-cycle multiply/divide engine:
// op codes, FSM state encoding and write-back select.
`default_nettype none

package muldiv_sequencer_pkg;

    localparam logic [1:0] MD_OP_NONE    = 2'b00;
    localparam logic [1:0] MD_OP_MUL     = 2'b01;
    localparam logic [1:0] MD_OP_DIV     = 2'b10;
    localparam logic [1:0] REGWRITE_DUAL = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_PREP = 2'b01,
        MD_RUN  = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_sequencer_md_step.sv
// One combinational iteration of the engine: unsigned shift-add multiply
// step or restoring shift-subtract divide step on a 2*WIDTH+1 bit accumulator.
`default_nettype none

module md_step #(
    parameter int WIDTH = 16
) (
    input  logic [1:0]         op_i,
    input  logic [2*WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    output logic [2*WIDTH:0]   acc_o
);
    import muldiv_sequencer_pkg::*;

    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH:0] div_shift;
    logic [WIDTH+1:0] div_trial;

    // Multiply: acc = {hi(W+1), multiplier(W)}; the extra hi bit holds the add carry.
    // Divide:   acc = {remainder(W+1), dividend/quotient(W)}.
    always_comb begin
        mul_sum   = acc_i[2*WIDTH:WIDTH] + {1'b0, operand_i};
        div_shift = {acc_i[2*WIDTH-1:0], 1'b0};
        div_trial = {1'b0, div_shift[2*WIDTH:WIDTH]} - {2'b00, operand_i};
        acc_o     = acc_i;
        if (op_i == MD_OP_MUL) begin
            if (acc_i[0]) begin
                acc_o = {1'b0, mul_sum, acc_i[WIDTH-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[2*WIDTH:1]};
            end
        end else if (op_i == MD_OP_DIV) begin
            if (!div_trial[WIDTH+1]) begin
                acc_o = {div_trial[WIDTH:0], div_shift[WIDTH-1:1], 1'b1};
            end else begin
                acc_o = div_shift;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply/divide sequencer: captures one op, stalls the
// pipeline while iterating, and presents a two-word result with a done pulse.
`default_nettype none

module muldiv_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_lo_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             div_by_zero_o
);
    import muldiv_sequencer_pkg::*;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_e        state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] abs_a_q;
    logic [WIDTH-1:0] abs_b_q;
    logic             neg_q;
    logic             rneg_q;
    logic [2*WIDTH:0] acc_q;
    logic [2*WIDTH:0] acc_d;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;

    logic               valid_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   step_operand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   lo_d;
    logic [WIDTH-1:0]   hi_d;

    assign valid_op     = start_i && (op_i == MD_OP_MUL || op_i == MD_OP_DIV);
    assign abs_a        = a_i[WIDTH-1] ? -a_i : a_i;
    assign abs_b        = b_i[WIDTH-1] ? -b_i : b_i;
    assign step_operand = (op_q == MD_OP_MUL) ? abs_a_q : abs_b_q;

    md_step #(.WIDTH(WIDTH)) u_md_step (
        .op_i      (op_q),
        .acc_i     (acc_q),
        .operand_i (step_operand),
        .acc_o     (acc_d)
    );

    // Sign correction applied to the final iteration's output as it is registered.
    assign prod   = acc_d[2*WIDTH-1:0];
    assign prod_s = neg_q ? -prod : prod;
    assign quo    = acc_d[WIDTH-1:0];
    assign rem    = acc_d[2*WIDTH-1:WIDTH];
    assign lo_d   = (op_q == MD_OP_MUL) ? prod_s[WIDTH-1:0] : (neg_q ? -quo : quo);
    assign hi_d   = (op_q == MD_OP_MUL) ? prod_s[2*WIDTH-1:WIDTH] : (rneg_q ? -rem : rem);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            op_q    <= MD_OP_NONE;
            a_q     <= '0;
            abs_a_q <= '0;
            abs_b_q <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            acc_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    done_q <= 1'b0;
                    if (valid_op && !flush_i) begin
                        op_q    <= op_i;
                        a_q     <= a_i;
                        abs_a_q <= abs_a;
                        abs_b_q <= abs_b;
                        neg_q   <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
                        rneg_q  <= a_i[WIDTH-1];
                        busy_q  <= 1'b1;
                        state_q <= MD_PREP;
                    end
                end
                MD_PREP: begin
                    if (flush_i) begin
                        busy_q  <= 1'b0;
                        state_q <= MD_IDLE;
                    end else if (op_q == MD_OP_DIV && abs_b_q == '0) begin
                        lo_q    <= '1;
                        hi_q    <= a_q;
                        dbz_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= MD_DONE;
                    end else begin
                        acc_q   <= (op_q == MD_OP_MUL) ? {{(WIDTH+1){1'b0}}, abs_b_q}
                                                       : {{(WIDTH+1){1'b0}}, abs_a_q};
                        count_q <= CW'(WIDTH - 1);
                        state_q <= MD_RUN;
                    end
                end
                MD_RUN: begin
                    if (flush_i) begin
                        busy_q  <= 1'b0;
                        state_q <= MD_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        if (count_q == '0) begin
                            lo_q    <= lo_d;
                            hi_q    <= hi_d;
                            dbz_q   <= 1'b0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= MD_DONE;
                        end else begin
                            count_q <= count_q - 1'b1;
                        end
                    end
                end
                MD_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= MD_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign stall_o       = busy_q | (valid_op & (state_q == MD_IDLE));
    assign result_lo_o   = lo_q;
    assign result_hi_o   = hi_q;
    assign div_by_zero_o = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// Directed and table-driven bench for muldiv_sequencer (WIDTH=16).
`default_nettype none

module tb_muldiv_sequencer;

    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        flush;
    logic        busy, stall, done, dbz;
    logic [15:0] lo, hi;

    int checks   = 0;
    int failures = 0;

    muldiv_sequencer #(.WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .op_i          (op),
        .a_i           (a),
        .b_i           (b),
        .flush_i       (flush),
        .busy_o        (busy),
        .stall_o       (stall),
        .done_o        (done),
        .result_lo_o   (lo),
        .result_hi_o   (hi),
        .div_by_zero_o (dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issues one op at a negedge (cycle T) and waits, bounded, for done.
    task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                          output int lat, output logic stall_ok);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        #1 stall_ok = stall;
        @(negedge clk);
        start = 1'b0; op = 2'b00;
        cyc = 1;
        while (!done && cyc < 60) begin
            if (!stall) stall_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        lat = cyc;
        if (stall) stall_ok = 1'b0;
    endtask

    task automatic watch_done(input int n, output logic seen);
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    initial begin
        int          lat;
        logic        sok;
        logic        seen;
        logic [15:0] save_lo, save_hi;
        int          ia, ib, eq, er;
        logic [31:0] ep;

        vecs[0]  = '{OP_MUL, 16'd7,    16'hFFFD, 16'hFFEB, 16'hFFFF, 1'b0, 18};
        vecs[1]  = '{OP_DIV, 16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0, 18};
        vecs[2]  = '{OP_DIV, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 18};
        vecs[3]  = '{OP_DIV, 16'd5,    16'd0,    16'hFFFF, 16'h0005, 1'b1, 2};
        vecs[4]  = '{OP_DIV, 16'd7,    16'd2,    16'h0003, 16'h0001, 1'b0, 18};
        vecs[5]  = '{OP_MUL, 16'd300,  16'd300,  16'h5F90, 16'h0001, 1'b0, 18};
        vecs[6]  = '{OP_DIV, 16'd1000, 16'd7,    16'd142,  16'd6,    1'b0, 18};
        vecs[7]  = '{OP_MUL, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0, 18};
        vecs[8]  = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 18};
        vecs[9]  = '{OP_DIV, 16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 18};
        vecs[10] = '{OP_DIV, 16'd7,    16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 18};
        vecs[11] = '{OP_MUL, 16'h8000, 16'h7FFF, 16'h8000, 16'hC000, 1'b0, 18};
        vecs[12] = '{OP_DIV, 16'd0,    16'd0,    16'hFFFF, 16'h0000, 1'b1, 2};
        vecs[13] = '{OP_DIV, 16'd3,    16'd5,    16'h0000, 16'h0003, 1'b0, 18};
        vecs[14] = '{OP_MUL, 16'd0,    16'h1234, 16'h0000, 16'h0000, 1'b0, 18};

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_lo", {16'd0, lo}, 32'd0);
        chk("reset_hi", {16'd0, hi}, 32'd0);
        chk("reset_dbz", {31'd0, dbz}, 32'd0);
        rst = 1'b0;

        // Table vectors run back to back: each start lands the cycle after DONE.
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, sok);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_stall", i), {31'd0, sok}, 32'd1);
            chk($sformatf("vec%0d_lo", i), {16'd0, lo}, {16'd0, vecs[i].lo});
            chk($sformatf("vec%0d_hi", i), {16'd0, hi}, {16'd0, vecs[i].hi});
            chk($sformatf("vec%0d_dbz", i), {31'd0, dbz}, {31'd0, vecs[i].dbz});
        end

        // Random signed operands against a behavioural model.
        for (int i = 0; i < 8; i++) begin
            ia = $signed(16'($urandom()));
            ib = $signed(16'($urandom()));
            if (i == 3) ib = 0;
            if (i[0]) begin
                ep = 32'(ia * ib);
                run_op(OP_MUL, 16'(ia), 16'(ib), lat, sok);
                chk($sformatf("rnd%0d_mul", i), {hi, lo}, ep);
            end else if (ib == 0) begin
                run_op(OP_DIV, 16'(ia), 16'(ib), lat, sok);
                chk($sformatf("rnd%0d_div0", i), {dbz, 15'd0, lo}, {1'b1, 15'd0, 16'hFFFF});
            end else begin
                eq = ia / ib;
                er = ia % ib;
                run_op(OP_DIV, 16'(ia), 16'(ib), lat, sok);
                chk($sformatf("rnd%0d_div", i), {hi, lo}, {16'(er), 16'(eq)});
            end
        end

        // Flush in RUN: back to IDLE next cycle, no done, results kept.
        save_lo = lo; save_hi = hi;
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 16'd9; b = 16'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        watch_done(25, seen);
        chk("flush_no_done", {31'd0, seen}, 32'd0);
        chk("flush_results", {hi, lo}, {save_hi, save_lo});

        // Reset in the middle of a divide clears every output.
        @(negedge clk);
        start = 1'b1; op = OP_DIV; a = 16'd100; b = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_outputs", {26'd0, busy, done, dbz, stall, (lo != 0), (hi != 0)}, 32'd0);
        run_op(OP_MUL, 16'hFFFE, 16'd3, lat, sok);
        chk("postrst_mul", {hi, lo}, 32'hFFFF_FFFA);
        chk("postrst_latency", lat, 18);

        // No-op codes never stall or launch anything.
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 16'd1; b = 16'd1;
        #1 chk("nop00_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        op = 2'b11;
        #1 chk("nop11_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; op = 2'b00;
        chk("nop_busy", {31'd0, busy}, 32'd0);
        watch_done(5, seen);
        chk("nop_no_done", {31'd0, seen}, 32'd0);

        // A second start while busy is ignored.
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 16'd7; b = 16'hFFFD;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = OP_DIV; a = 16'd5; b = 16'd0;
        @(negedge clk);
        start = 1'b0; op = 2'b00;
        lat = 4;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("busy_start_latency", lat, 18);
        chk("busy_start_result", {15'd0, dbz, lo}, {16'd0, 16'hFFEB});
        watch_done(25, seen);
        chk("busy_start_no_second_done", {31'd0, seen}, 32'd0);

        // Flush and start together in IDLE: start dropped.
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 16'd2; b = 16'd2; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        watch_done(22, seen);
        chk("flush_start_no_done", {31'd0, seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
